// File: rtl/qr_matrix_feeder.sv
// Ping-pong matrix buffer that replays each stored 4xNCOL matrix column by column
// as contiguous, zero-padded FRAME_LEN-cycle frames for the systolic CORDIC QR array.
module qr_matrix_feeder #(
  parameter int unsigned DATA_W    = 17,
  parameter int unsigned NCOL      = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              qr_valid,
  output logic [DATA_W-1:0] qr_in_1,
  output logic [DATA_W-1:0] qr_in_2,
  output logic [DATA_W-1:0] qr_in_3,
  output logic [DATA_W-1:0] qr_in_4,
  output logic              frame_start
);

  localparam int unsigned NROW  = 4;
  localparam int unsigned DEPTH = NROW * NCOL;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  logic [DATA_W-1:0] r_mem [2][DEPTH];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic [IDX_W-1:0]  r_wr_idx;
  logic              r_rd_bank;
  logic [CNT_W-1:0]  r_frame_cnt;
  state_t            r_state;
  logic [DATA_W-1:0] r_qr [NROW];
  logic              r_qr_valid;
  logic              r_frame_start;

  logic w_accept;
  logic w_wr_last;
  logic w_frame_end;

  // Ready depends on registered flags only; held low during reset.
  assign s_ready     = !rst && !r_full[r_wr_bank];
  assign w_accept    = s_valid && s_ready;
  assign w_wr_last   = (r_wr_idx == IDX_W'(DEPTH - 1));
  assign w_frame_end = (r_frame_cnt == CNT_W'(FRAME_LEN - 1));

  assign qr_valid    = r_qr_valid;
  assign frame_start = r_frame_start;
  assign qr_in_1     = r_qr[0];
  assign qr_in_2     = r_qr[1];
  assign qr_in_3     = r_qr[2];
  assign qr_in_4     = r_qr[3];

  // Row element of a column; columns at or beyond NCOL are zero padding.
  function automatic logic [DATA_W-1:0] col_elem(input logic             bank,
                                                 input logic [CNT_W-1:0] col,
                                                 input int unsigned      row);
    logic [DATA_W-1:0] v;
    v = '0;
    if (32'(col) < NCOL) v = r_mem[bank][IDX_W'(row * NCOL + 32'(col))];
    return v;
  endfunction

  // Storage carries no reset: a bank is only read after it has been completely rewritten.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_bank][r_wr_idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full        <= '0;
      r_wr_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_rd_bank     <= 1'b0;
      r_frame_cnt   <= '0;
      r_state       <= ST_IDLE;
      r_qr_valid    <= 1'b0;
      r_frame_start <= 1'b0;
      for (int unsigned r = 0; r < NROW; r++) r_qr[r] <= '0;
    end else begin
      if (w_accept) begin
        r_wr_idx <= w_wr_last ? '0 : r_wr_idx + IDX_W'(1);
        if (w_wr_last) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end
      end

      // Writer and reader never touch the same full bit on one edge: a full bank refuses writes.
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state       <= ST_STREAM;
            r_frame_cnt   <= '0;
            r_qr_valid    <= 1'b1;
            r_frame_start <= 1'b1;
            for (int unsigned r = 0; r < NROW; r++) r_qr[r] <= col_elem(r_rd_bank, '0, r);
          end
        end
        ST_STREAM: begin
          if (w_frame_end) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
            r_frame_cnt       <= '0;
            if (r_full[~r_rd_bank]) begin
              r_frame_start <= 1'b1;
              for (int unsigned r = 0; r < NROW; r++) r_qr[r] <= col_elem(~r_rd_bank, '0, r);
            end else begin
              r_state       <= ST_IDLE;
              r_qr_valid    <= 1'b0;
              r_frame_start <= 1'b0;
              for (int unsigned r = 0; r < NROW; r++) r_qr[r] <= '0;
            end
          end else begin
            r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
            r_frame_start <= 1'b0;
            for (int unsigned r = 0; r < NROW; r++)
              r_qr[r] <= col_elem(r_rd_bank, r_frame_cnt + CNT_W'(1), r);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
